// File: rtl/conv_param_calc_if.sv
// Handshake and result bundle between the layer geometry calculator and its control unit.
// Carries the optional pad field when CONV_PAD_EN is defined.
interface conv_param_calc_if #(
   parameter int TENSOR_W = 8,
   parameter int KERNEL_W = 4,
   parameter int STRIDE_W = 3
);
   logic                  calc_start;
   logic [TENSOR_W-1:0]   tensor_size;
   logic [KERNEL_W-1:0]   kernel_size;
   logic [STRIDE_W-1:0]   stride;
`ifdef CONV_PAD_EN
   logic [1:0]            pad;
`endif
   logic                  busy;
   logic                  para_done;
   logic                  param_err;
   logic [TENSOR_W-1:0]   n_ofs;
   logic [2*TENSOR_W:0]   n_T_sub_K_div_S2;

   modport master (
`ifdef CONV_PAD_EN
      output pad,
`endif
      output calc_start, tensor_size, kernel_size, stride,
      input  busy, para_done, param_err, n_ofs, n_T_sub_K_div_S2
   );

   modport slave (
`ifdef CONV_PAD_EN
      input  pad,
`endif
      input  calc_start, tensor_size, kernel_size, stride,
      output busy, para_done, param_err, n_ofs, n_T_sub_K_div_S2
   );
endinterface

// File: rtl/conv_param_calc.sv
// Next-layer geometry: ofs = (T+2P-K)/S via restoring divider, area = (ofs+1)^2.
// CONV_PAD_EN adds the pad input and widens the divider by two bits.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for calc_start with enable high
// S_CHECK  | validate geometry, load divider
// S_DIV    | one quotient bit per cycle, MSB first
// S_SQUARE | register ofs and (ofs+1)^2
// S_DONE   | publish results, pulse para_done on the following cycle
module conv_param_calc #(
   parameter int TENSOR_W = 8,
   parameter int KERNEL_W = 4,
   parameter int STRIDE_W = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   conv_param_calc_if.slave  bus
);

`ifdef CONV_PAD_EN
   localparam int DIV_W  = TENSOR_W + 2;
`else
   localparam int DIV_W  = TENSOR_W;
`endif
   localparam int AREA_W = 2*TENSOR_W + 1;
   localparam int CNT_W  = $clog2(DIV_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_DIV,
      S_SQUARE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic cap_en, load_en, div_en, sq_en, done_en;

   logic [TENSOR_W-1:0] t_q;
   logic [KERNEL_W-1:0] k_q;
   logic [STRIDE_W-1:0] s_q;
`ifdef CONV_PAD_EN
   logic [1:0]          p_q;
`endif

   logic [DIV_W-1:0]    dvd_q;
   logic [DIV_W:0]      rem_q;
   logic [DIV_W-1:0]    quo_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                err_q;
   logic [TENSOR_W-1:0] ofs_q;
   logic [AREA_W-1:0]   area_q;

   logic                para_done_q;
   logic                param_err_q;
   logic [TENSOR_W-1:0] n_ofs_q;
   logic [AREA_W-1:0]   n_area_q;

   logic [DIV_W-1:0]    t_eff;
   logic [DIV_W-1:0]    k_ext;
   logic [DIV_W-1:0]    dividend;
   logic                geom_err;
   logic [DIV_W:0]      div_ext;
   logic [DIV_W:0]      rem_shift;
   logic [DIV_W+1:0]    diff;
   logic                q_bit;
   logic [DIV_W-1:0]    quo_nxt;
   logic [AREA_W-1:0]   ofs_inc;
   logic [AREA_W-1:0]   area_nxt;

   // Geometry check and divider datapath
   always_comb begin
`ifdef CONV_PAD_EN
      t_eff = DIV_W'(t_q) + DIV_W'({p_q, 1'b0});
`else
      t_eff = DIV_W'(t_q);
`endif
      k_ext     = DIV_W'(k_q);
      geom_err  = (k_ext > t_eff) || (s_q == '0);
      dividend  = t_eff - k_ext;
      div_ext   = (DIV_W+1)'(s_q);
      rem_shift = {rem_q[DIV_W-1:0], dvd_q[DIV_W-1]};
      diff      = {1'b0, rem_shift} - {1'b0, div_ext};
      q_bit     = ~diff[DIV_W+1];
      quo_nxt   = {quo_q[DIV_W-2:0], q_bit};
      ofs_inc   = AREA_W'(quo_q[TENSOR_W-1:0]) + AREA_W'(1);
      area_nxt  = ofs_inc * ofs_inc;
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_en    = 1'b0;
      load_en   = 1'b0;
      div_en    = 1'b0;
      sq_en     = 1'b0;
      done_en   = 1'b0;
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.calc_start) begin
                  cap_en    = 1'b1;
                  state_nxt = S_CHECK;
               end
            end
            S_CHECK: begin
               load_en   = 1'b1;
               state_nxt = geom_err ? S_DONE : S_DIV;
            end
            S_DIV: begin
               div_en = 1'b1;
               if (cnt_q == '0) state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
               sq_en     = 1'b1;
               state_nxt = S_DONE;
            end
            S_DONE: begin
               done_en   = 1'b1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         t_q         <= '0;
         k_q         <= '0;
         s_q         <= '0;
`ifdef CONV_PAD_EN
         p_q         <= '0;
`endif
         dvd_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ofs_q       <= '0;
         area_q      <= '0;
         para_done_q <= 1'b0;
         param_err_q <= 1'b0;
         n_ofs_q     <= '0;
         n_area_q    <= '0;
      end else begin
         para_done_q <= 1'b0;
         if (cap_en) begin
            t_q <= bus.tensor_size;
            k_q <= bus.kernel_size;
            s_q <= bus.stride;
`ifdef CONV_PAD_EN
            p_q <= bus.pad;
`endif
         end
         if (load_en) begin
            err_q <= geom_err;
            if (!geom_err) begin
               dvd_q <= dividend;
               rem_q <= '0;
               quo_q <= '0;
               cnt_q <= CNT_W'(DIV_W - 1);
            end
         end
         if (div_en) begin
            dvd_q <= {dvd_q[DIV_W-2:0], 1'b0};
            rem_q <= q_bit ? diff[DIV_W:0] : rem_shift;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (sq_en) begin
            ofs_q  <= quo_q[TENSOR_W-1:0];
            area_q <= area_nxt;
`ifdef CONV_PAD_EN
            // Padding can push the quotient past what n_ofs can represent
            err_q  <= err_q | (|quo_q[DIV_W-1:TENSOR_W]);
`endif
         end
         if (done_en) begin
            para_done_q <= 1'b1;
            param_err_q <= err_q;
            n_ofs_q     <= err_q ? '0 : ofs_q;
            n_area_q    <= err_q ? '0 : area_q;
         end
      end
   end

   assign bus.busy             = (state != S_IDLE) | para_done_q;
   assign bus.para_done        = para_done_q;
   assign bus.param_err        = param_err_q;
   assign bus.n_ofs            = n_ofs_q;
   assign bus.n_T_sub_K_div_S2 = n_area_q;

endmodule

// File: tb/tb_conv_param_calc.sv
// Scoreboarded bench for conv_param_calc: directed corner cases plus random geometry
// checked against an arithmetic reference model.
module tb_conv_param_calc;
   localparam int TW = 8;
   localparam int KW = 4;
   localparam int SW = 3;
`ifdef CONV_PAD_EN
   localparam int DIV_LAT = TW + 2 + 3;
`else
   localparam int DIV_LAT = TW + 3;
`endif
   localparam int OFS_MAX = (1 << TW) - 1;

   logic clk    = 1'b0;
   logic rstn   = 1'b0;
   logic enable = 1'b0;

   conv_param_calc_if #(.TENSOR_W(TW), .KERNEL_W(KW), .STRIDE_W(SW)) bus ();

   conv_param_calc #(.TENSOR_W(TW), .KERNEL_W(KW), .STRIDE_W(SW)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit err;
      int ofs;
      int area;
      int edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   bit   prev_pd     = 1'b0;
   int   last_ofs    = 0;
   int   last_area   = 0;
   bit   last_err    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: plain integer geometry arithmetic
   function automatic exp_t model(input int t, input int k, input int s, input int p,
                                  input int start_edge);
      exp_t e;
      int   te;
      te     = t + 2*p;
      e.err  = 1'b0;
      e.ofs  = 0;
      e.area = 0;
      if (k > te || s == 0) begin
         e.err     = 1'b1;
         e.edge_no = start_edge + 2;
      end else begin
         e.edge_no = start_edge + DIV_LAT;
         e.ofs     = (te - k) / s;
         if (e.ofs > OFS_MAX) begin
            e.err = 1'b1;
            e.ofs = 0;
         end else begin
            e.area = (e.ofs + 1) * (e.ofs + 1);
         end
      end
      return e;
   endfunction

   // Monitor: samples 1 time unit after each rising edge
   always @(posedge clk) begin
      #1;
      if (bus.para_done === 1'b1) begin
         check("pd_single_cycle", longint'(prev_pd), 0);
         if (exp_q.size() == 0) begin
            check("spurious_para_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("latency_edge", longint'(cyc), longint'(e.edge_no));
            check("param_err", longint'(bus.param_err), longint'(e.err));
            check("n_ofs", longint'(bus.n_ofs), longint'(e.ofs));
            check("area", longint'(bus.n_T_sub_K_div_S2), longint'(e.area));
            check("busy_at_done", longint'(bus.busy), 1);
            last_ofs  = e.ofs;
            last_area = e.area;
            last_err  = e.err;
         end
      end
      prev_pd = (bus.para_done === 1'b1);
   end

   task automatic drive_start(input int t, input int k, input int s, input int p,
                              input bit expect_accept);
      @(negedge clk);
      bus.tensor_size = TW'(t);
      bus.kernel_size = KW'(k);
      bus.stride      = SW'(s);
`ifdef CONV_PAD_EN
      bus.pad         = 2'(p);
`endif
      bus.calc_start  = 1'b1;
      if (expect_accept) exp_q.push_back(model(t, k, s, p, cyc + 1));
      @(negedge clk);
      bus.calc_start  = 1'b0;
      bus.tensor_size = TW'($urandom);
      bus.kernel_size = KW'($urandom);
      bus.stride      = SW'($urandom);
`ifdef CONV_PAD_EN
      bus.pad         = 2'($urandom);
`endif
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("timeout_waiting_para_done", 0, 1);
         exp_q.delete();
      end
   endtask

   task automatic run(input int t, input int k, input int s, input int p);
      drive_start(t, k, s, p, 1'b1);
      wait_drain(40);
      @(negedge clk);
      check("busy_after_done", longint'(bus.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, k, s, p;
      bus.calc_start  = 1'b0;
      bus.tensor_size = '0;
      bus.kernel_size = '0;
      bus.stride      = '0;
`ifdef CONV_PAD_EN
      bus.pad         = '0;
`endif
      rstn   = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_para_done", longint'(bus.para_done), 0);
      check("rst_param_err", longint'(bus.param_err), 0);
      check("rst_n_ofs", longint'(bus.n_ofs), 0);
      check("rst_area", longint'(bus.n_T_sub_K_div_S2), 0);
      rstn = 1'b1;
      @(negedge clk);

      run(8, 3, 1, 0);
      run(28, 5, 2, 0);
      run(255, 1, 1, 0);
      run(8, 9, 1, 0);
      run(8, 3, 0, 0);
      run(7, 7, 3, 0);
`ifdef CONV_PAD_EN
      run(28, 3, 1, 1);
      run(255, 1, 1, 3);
      run(1, 5, 1, 2);
`endif

      // Restart attempt 4 cycles into a run must be ignored
      drive_start(8, 3, 1, 0, 1'b1);
      repeat (3) @(negedge clk);
      drive_start(16, 3, 1, 0, 1'b0);
      wait_drain(40);
      repeat (15) @(negedge clk);

      // Start landing on the DONE cycle of the error path is ignored
      drive_start(8, 9, 1, 0, 1'b1);
      drive_start(20, 3, 1, 0, 1'b0);
      wait_drain(40);
      repeat (15) @(negedge clk);

      // Reset mid-divide clears everything and suppresses para_done
      run(8, 3, 1, 0);
      drive_start(8, 3, 1, 0, 1'b1);
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_para_done", longint'(bus.para_done), 0);
      check("midrst_n_ofs", longint'(bus.n_ofs), 0);
      check("midrst_area", longint'(bus.n_T_sub_K_div_S2), 0);
      rstn = 1'b1;
      repeat (15) @(negedge clk);

      // Enable dropped mid-divide: abort, outputs hold
      run(28, 5, 2, 0);
      drive_start(8, 3, 1, 0, 1'b1);
      repeat (4) @(negedge clk);
      enable = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("en_busy", longint'(bus.busy), 0);
      check("en_hold_ofs", longint'(bus.n_ofs), longint'(last_ofs));
      check("en_hold_area", longint'(bus.n_T_sub_K_div_S2), longint'(last_area));
      check("en_hold_err", longint'(bus.param_err), longint'(last_err));
      drive_start(8, 3, 1, 0, 1'b0);
      repeat (15) @(negedge clk);
      check("en_low_start_busy", longint'(bus.busy), 0);
      enable = 1'b1;
      run(8, 3, 1, 0);

      for (int i = 0; i < 40; i++) begin
         t = $urandom_range(0, 255);
         if ($urandom_range(0, 3) == 0) t = $urandom_range(0, 15);
         k = $urandom_range(0, 15);
         s = $urandom_range(0, 7);
`ifdef CONV_PAD_EN
         p = $urandom_range(0, 3);
`else
         p = 0;
`endif
         run(t, k, s, p);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/conv_param_calc.md
Name: conv_param_calc

Overview:
Next-layer geometry calculator that sits directly upstream of the convolution control unit. On a start pulse it computes the last output index ofs = (T-K)/S and the output plane area (ofs+1)^2 using an iterative restoring divider and a single-cycle multiply. It then pulses para_done so the control unit can latch the next layer's tensor size and ifmap count. Invalid geometry is flagged rather than computed.

Parameters:
TENSOR_W, 8, width of tensor size and ofs (matches `TENSOR_SIZE)
KERNEL_W, 4, width of kernel size (matches `KERNEL_SIZE)
STRIDE_W, 3, width of stride (matches `STRIDE_SIZE)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset; sampled on rising edge of clk
enable  in  1  system enable; low forces FSM to IDLE
calc_start  in  1  single-cycle start pulse
tensor_size  in  TENSOR_W  input feature map side T
kernel_size  in  KERNEL_W  kernel side K
stride  in  STRIDE_W  stride S
busy  out  1  high from cycle after accepted start until para_done cycle inclusive
para_done  out  1  one-cycle result-valid pulse (to control unit n_para_done)
param_err  out  1  valid with para_done; 1 = K>T or S==0
n_ofs  out  TENSOR_W  (T-K)/S, floor
n_T_sub_K_div_S2  out  2*TENSOR_W+1  (n_ofs+1)^2

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE; busy, para_done, param_err, n_ofs, n_T_sub_K_div_S2 all 0; divider registers 0. Reset mid-operation aborts with no para_done.
- FSM states: IDLE, CHECK, DIV, SQUARE, DONE.
- IDLE: calc_start=1 and enable=1 -> capture T, K, S into internal registers; go to CHECK. calc_start while not IDLE is ignored (no restart, no queueing).
- CHECK (1 cycle): if K>T or S==0 -> DONE with error flag set; else load dividend T-K (TENSOR_W bits, unsigned), quotient 0, bit counter TENSOR_W-1; go to DIV.
- DIV: restoring division, one quotient bit per cycle MSB-first, exactly TENSOR_W cycles; divisor zero-extended to TENSOR_W+1 bits; after final bit go to SQUARE.
- SQUARE (1 cycle): register ofs=quotient and area=(ofs+1)*(ofs+1), computed at 2*TENSOR_W+1 bits (no overflow possible).
- DONE (1 cycle): para_done=1; update n_ofs/n_T_sub_K_div_S2 (error: both 0) and param_err; return to IDLE.
- Latency: start sampled at edge e0; para_done high during cycle following edge e0+TENSOR_W+3 (TENSOR_W=8: para_done visible 11 cycles after start edge). Error path: para_done 2 cycles after start edge.
- n_ofs, n_T_sub_K_div_S2, param_err hold last values until next DONE; para_done is never high two consecutive cycles.
- enable=0 in any state: next edge returns to IDLE, busy=0, outputs hold, no para_done. calc_start with enable=0 ignored.
- Simultaneous calc_start and DONE: start ignored (not IDLE); must be reissued.
- Inputs may change after start; only captured values are used.

Optional Feature:
CONV_PAD_EN: when defined, adds input port pad (width 2, padding P) captured with the others; dividend becomes T+2P-K computed at TENSOR_W+2 bits, DIV runs TENSOR_W+2 cycles (latency +2), error also if K>T+2P or quotient exceeds 2^TENSOR_W-1. When undefined, no pad port, P treated as 0, timing as above.

Test Plan:
T=8,K=3,S=1, start pulse -> after 11 cycles para_done=1, n_ofs=5, n_T_sub_K_div_S2=36, param_err=0, busy low next cycle.
T=28,K=5,S=2 -> n_ofs=11, area=144; T=255,K=1,S=1 -> n_ofs=254, area=65025.
K=9,T=8,S=1 -> para_done 2 cycles after start, param_err=1, n_ofs=0, area=0; repeat with S=0,T=8,K=3 -> same.
Second calc_start 4 cycles into a T=8,K=3,S=1 run with T=16 -> ignored, single para_done, n_ofs=5; rstn=0 mid-DIV -> no para_done, all outputs 0.
enable dropped mid-DIV -> FSM IDLE, no para_done, prior outputs held; new start after enable=1 completes normally.
CONV_PAD_EN defined: T=28,K=3,S=1,P=1 -> para_done after 13 cycles, n_ofs=27, area=784.
